// File: rtl/cci_mpf_prim_ram_arb_pkg.sv
// Shared types and helpers for the byte-enabled RAM port-0 arbiter and its
// round-robin grant block.
package cci_mpf_prim_ram_arb_pkg;

    // Requester count the index type is sized for; the arbiter top defaults to it.
    localparam int unsigned ARB_N_REQ = 4;
    localparam int unsigned ARB_IDX_W = (ARB_N_REQ > 1) ? $clog2(ARB_N_REQ) : 1;
    localparam int unsigned STAT_W    = 32;

    typedef logic [ARB_IDX_W-1:0] t_req_idx;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } t_arb_state;

    typedef struct packed {
        logic     valid;
        t_req_idx idx;
    } t_rsp_pipe_ent;

    // Pointer after a handshake by requester g: (g + 1) mod n.
    function automatic t_req_idx rr_next_ptr(input t_req_idx g, input int unsigned n);
        logic [31:0] nxt;
        nxt = 32'(g) + 32'd1;
        return (nxt >= n) ? '0 : t_req_idx'(nxt);
    endfunction

endpackage

// File: rtl/cci_mpf_prim_rr_arb.sv
// Combinational round-robin grant: searches ptr, ptr+1, ... wrapping at N and
// grants the first requester found. The pointer register lives in the caller.
module cci_mpf_prim_rr_arb #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] grant_idx_c,
    output logic          grant_valid_c
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_c       = '0;
        grant_idx_c   = '0;
        grant_valid_c = 1'b0;
        cand          = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!grant_valid_c && req[cand]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = cand;
            end
        end
        if (grant_valid_c) begin
            grant_c = N'(1) << grant_idx_c;
        end
    end

endmodule

// File: rtl/cci_mpf_prim_ram_byteena_arb.sv
// Shares port 0 of a byte-enabled block RAM among N_REQ requesters after an
// init sweep. CCI_MPF_PRIM_RAM_ARB_STATS_EN adds grant/stall counters.
module cci_mpf_prim_ram_byteena_arb
    import cci_mpf_prim_ram_arb_pkg::*;
#(
    parameter int unsigned N_REQ               = ARB_N_REQ,
    parameter int unsigned N_ENTRIES           = 512,
    parameter int unsigned N_DATA_BITS         = 64,
    parameter int unsigned N_BYTE_BITS         = 8,
    parameter int unsigned N_OUTPUT_REG_STAGES = 1,
    parameter logic [N_DATA_BITS-1:0] INIT_VALUE = '0,
    localparam int unsigned AW = $clog2(N_ENTRIES),
    localparam int unsigned NB = N_DATA_BITS / N_BYTE_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         rdy,

    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0]             req_wen,
    input  logic [N_REQ*AW-1:0]          req_addr,
    input  logic [N_REQ*NB-1:0]          req_byteena,
    input  logic [N_REQ*N_DATA_BITS-1:0] req_wdata,

    output logic [N_REQ-1:0]             rsp_valid,
    output logic [N_DATA_BITS-1:0]       rsp_rdata,
`ifdef CCI_MPF_PRIM_RAM_ARB_STATS_EN
    output logic [N_REQ*STAT_W-1:0]      stat_grants,
    output logic [STAT_W-1:0]            stat_stall,
`endif
    output logic [AW-1:0]                ram_addr,
    output logic                         ram_wen,
    output logic [NB-1:0]                ram_byteena,
    output logic [N_DATA_BITS-1:0]       ram_wdata,
    input  logic [N_DATA_BITS-1:0]       ram_rdata
);

    localparam int unsigned RD_LAT = 1 + N_OUTPUT_REG_STAGES;

    t_arb_state                  state_q, state_d;
    logic [AW-1:0]               init_addr_q, init_addr_d;
    logic                        rdy_q, rdy_d;
    t_req_idx                    ptr_q, ptr_d;
    t_rsp_pipe_ent [RD_LAT-1:0]  pipe_q, pipe_d;

    logic [N_REQ-1:0]            arb_req;
    logic [N_REQ-1:0]            grant;
    t_req_idx                    grant_idx;
    logic                        grant_valid;
    logic                        rd_issue;

    logic                        sel_wen;
    logic [AW-1:0]               sel_addr;
    logic [NB-1:0]               sel_be;
    logic [N_DATA_BITS-1:0]      sel_wdata;

    // Requests are invisible to the arbiter until the sweep has finished.
    assign arb_req = (state_q == ST_RUN) ? req_valid : '0;

    cci_mpf_prim_rr_arb #(
        .N (N_REQ)
    ) u_rr_arb (
        .req           (arb_req),
        .ptr           (ptr_q),
        .grant_c       (grant),
        .grant_idx_c   (grant_idx),
        .grant_valid_c (grant_valid)
    );

    assign sel_wen   = req_wen[grant_idx];
    assign sel_addr  = req_addr[32'(grant_idx)*AW +: AW];
    assign sel_be    = req_byteena[32'(grant_idx)*NB +: NB];
    assign sel_wdata = req_wdata[32'(grant_idx)*N_DATA_BITS +: N_DATA_BITS];

    // Next-state, pointer and RAM port drive.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        rdy_d       = rdy_q;
        ptr_d       = ptr_q;
        req_ready   = '0;
        rd_issue    = 1'b0;
        ram_wen     = 1'b0;
        ram_addr    = init_addr_q;
        ram_byteena = '1;
        ram_wdata   = INIT_VALUE;

        case (state_q)
            ST_INIT: begin
                // Held off while reset is asserted so no write leaks out.
                ram_wen     = !reset;
                init_addr_d = init_addr_q + AW'(1);
                if (init_addr_q == AW'(N_ENTRIES - 1)) begin
                    state_d     = ST_RUN;
                    rdy_d       = 1'b1;
                    init_addr_d = '0;
                end
            end
            ST_RUN: begin
                req_ready = grant;
                ram_addr  = sel_addr;
                ram_wdata = sel_wdata;
                if (grant_valid) begin
                    ram_wen  = sel_wen;
                    rd_issue = !sel_wen;
                    ptr_d    = rr_next_ptr(grant_idx, N_REQ);
                    if (sel_wen) begin
                        ram_byteena = sel_be;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Read-latency tracker: entry enters at stage 0, exits RD_LAT cycles later.
    always_comb begin
        pipe_d           = pipe_q;
        pipe_d[0].valid  = rd_issue;
        pipe_d[0].idx    = grant_idx;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            rdy_q       <= 1'b0;
            ptr_q       <= '0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            rdy_q       <= rdy_d;
            ptr_q       <= ptr_d;
            pipe_q      <= pipe_d;
        end
    end

    assign rdy       = rdy_q;
    assign rsp_valid = pipe_q[RD_LAT-1].valid ? (N_REQ'(1) << pipe_q[RD_LAT-1].idx) : '0;
    assign rsp_rdata = ram_rdata;

`ifdef CCI_MPF_PRIM_RAM_ARB_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] grants_q, grants_d;
    logic [STAT_W-1:0]            stall_q, stall_d;

    // Saturating counters, active only once the sweep is done.
    always_comb begin
        grants_d = grants_q;
        stall_d  = stall_q;
        if (state_q == ST_RUN) begin
            if (grant_valid && (grants_q[grant_idx] != '1)) begin
                grants_d[grant_idx] = grants_q[grant_idx] + STAT_W'(1);
            end
            if (((req_valid & ~grant) != '0) && (stall_q != '1)) begin
                stall_d = stall_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grants_q <= '0;
            stall_q  <= '0;
        end else begin
            grants_q <= grants_d;
            stall_q  <= stall_d;
        end
    end

    assign stat_grants = grants_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: doc/cci_mpf_prim_ram_byteena_arb.md
Name: cci_mpf_prim_ram_byteena_arb

Overview:
Sequences and shares port 0 of a byte-enabled dual-port block RAM (DUAL_PORT/BIDIR, 1 + N_OUTPUT_REG_STAGES read latency) among N_REQ requesters.
- After reset, sweeps every entry to INIT_VALUE with full byte enables, then raises rdy.
- Afterwards, grants one read or byte-masked write per cycle, round-robin.
- Tracks read latency and steers each read response back to its issuer.
- Sits between MPF client logic and the RAM primitive; port 1 of the RAM is untouched.

Parameters:
N_REQ, 4, number of requesters (≥2).
N_ENTRIES, 512, RAM depth; address width AW = $clog2(N_ENTRIES).
N_DATA_BITS, 64, data width.
N_BYTE_BITS, 8, byte size; NB = N_DATA_BITS / N_BYTE_BITS.
N_OUTPUT_REG_STAGES, 1, matches the RAM instance; RD_LAT = 1 + N_OUTPUT_REG_STAGES.
INIT_VALUE, N_DATA_BITS'(0), value written during the init sweep.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rdy  out  1  init sweep complete; stays high until the next reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  one-hot grant this cycle
req_wen  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ×AW  per-requester address
req_byteena  in  N_REQ×NB  per-requester write byte mask
req_wdata  in  N_REQ×N_DATA_BITS  per-requester write data
rsp_valid  out  N_REQ  one-hot read-data valid
rsp_rdata  out  N_DATA_BITS  read data, shared bus
ram_addr  out  AW  to RAM addr0
ram_wen  out  1  to RAM wen0
ram_byteena  out  NB  to RAM byteena0
ram_wdata  out  N_DATA_BITS  to RAM wdata0
ram_rdata  in  N_DATA_BITS  from RAM rdata0

Behaviour:
- Reset values: rdy=0, req_ready=0, rsp_valid=0, ram_wen=0, init address=0, round-robin pointer=0, response pipe empty.
- State machine, two states:
  - INIT:
    - Each cycle drives ram_wen=1, ram_byteena=all-ones, ram_wdata=INIT_VALUE, ram_addr=init address; init address increments.
    - After the write to N_ENTRIES-1, moves to RUN and sets rdy=1 on the next edge.
    - req_ready=0 throughout INIT.
  - RUN:
    - Arbitration is combinational over req_valid.
    - Priority starts at pointer p and searches p, p+1, …, wrapping at N_REQ.
    - Winner g gets req_ready[g]=1. Its wen/addr/byteena/wdata are muxed onto ram_* in the same cycle.
    - A handshake is req_valid[g] & req_ready[g]. On a handshake, p ← (g+1) mod N_REQ.
    - No valid requester: req_ready=0, ram_wen=0, p unchanged.
    - req_ready never asserts for a requester whose req_valid=0.
- Reads are not byte-masked. ram_byteena is driven with the requester value only when wen=1 and is all-ones otherwise.
- Response pipe: RD_LAT-deep shift register of {valid, requester index}. A read handshake enters the pipe.
  - After exactly RD_LAT cycles: rsp_valid[idx]=1 and rsp_rdata=ram_rdata.
  - Writes produce no response.
  - rsp_rdata is don't-care when no bit of rsp_valid is set.
- Throughput: one request per cycle. Responses return in issue order with no backpressure; requesters must always accept them.
- Same-address write at cycle t, read at t+1: the read returns the new data (port RDW mode NEW_DATA_NO_NBE_READ). Write and read in the same cycle cannot occur (one port).
- Reset mid-operation: pipe flushed, no rsp_valid issued for in-flight reads, returns to INIT and re-sweeps.

Optional Feature:
CCI_MPF_PRIM_RAM_ARB_STATS_EN
- Defined: adds output stat_grants, N_REQ×32, per-requester saturating grant counters.
- Also adds output stat_stall, 32 bits, counting cycles with a valid requester that was not granted.
- Counters clear on reset and do not count during INIT.
- Undefined: the ports and counters do not exist.

Decomposition:
- Package cci_mpf_prim_ram_arb_pkg:
  - typedef t_req_idx = logic [$clog2(N_REQ)-1:0].
  - Response-pipe entry struct {valid, idx}.
  - Helper function for round-robin next-pointer.
- One sub-module, cci_mpf_prim_rr_arb: combinational grant from req vector plus registered pointer. Reusable by other MPF arbiters.

Test Plan:
1. N_ENTRIES=16, reset release → rdy rises exactly 16 cycles later, ram_wen=1 on those 16 cycles; a read of addr 5 returns 0.
2. All 4 requesters valid continuously → grants 0,1,2,3,0,… one per cycle, no gaps.
3. Requester 2 writes addr 3 = 0x1122334455667788 with byteena=0x0F, then requester 1 reads addr 3 → rsp_valid=0b0010 RD_LAT cycles later, data 0x0000000055667788.
4. Back-to-back reads by requesters 0 and 3 to addrs 1 and 2 holding 0xA and 0xB → rsp_valid 0b0001 with 0xA, then 0b1000 with 0xB on consecutive cycles.
5. Assert reset while 2 reads are in flight → no rsp_valid after reset; rdy=0 and the sweep restarts from addr 0.
6. With CCI_MPF_PRIM_RAM_ARB_STATS_EN, 3 requesters valid for 9 cycles → stat_grants = 3,3,3,0 and stat_stall = 9.
